// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg
//   Shared types and defaults for the SAR ADC controller.
//   - sar_state_e : controller state encoding (3 bits)
//   - DEF_*       : default parameter values
//   - cnt_width() : bits needed by the phase timer
package sar_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    // The timer counts down from (cycles-1) to 0, so it must hold max-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for asynchronous level inputs.
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset, clears both stages
//     d_i   : asynchronous input
//     q_o   : synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl
//   Successive-approximation ADC controller. Drives the R2R DAC code,
//   reads the external comparator through a 2-flop synchronizer and
//   binary-searches the input into a WIDTH-bit result.
//   Ports:
//     clk       : system clock
//     rst_n     : asynchronous active-low reset
//     start     : level; begins a conversion when sampled high while idle/done
//     abort     : cancels a conversion in progress (priority over start)
//     cmp_in    : asynchronous comparator, 1 = Vin >= Vdac
//     dac_code  : code to the DAC
//     sample_en : track/hold control, high during SAMPLE
//     busy      : high in SAMPLE, SETTLE, DECIDE
//     done      : one-cycle pulse when result updates
//     result    : last completed conversion
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start, DAC parked at 0
//   SAMPLE | track/hold acquiring for SAMPLE_CYCLES
//   SETTLE | trial code on the DAC, waiting SETTLE_CYCLES for cmp_s
//   DECIDE | keep/clear current bit, set next trial bit
//   DONE   | result loaded, done pulsed; may chain straight into SAMPLE
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             sample_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    // Two synchronizer flops plus one cycle of DAC settling must fit
    // inside the settle window.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 3");
        end
        if (SAMPLE_CYCLES < 1) begin : g_bad_sample
            $error("sar_adc_ctrl: SAMPLE_CYCLES must be >= 1");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("sar_adc_ctrl: WIDTH must be >= 2");
        end
    endgenerate

    sar_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] trial_q;
    logic [WIDTH-1:0] dac_q;
    logic             sample_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             cmp_s;
    logic [WIDTH-1:0] cur_mask;
    logic [WIDTH-1:0] kept;
    logic [WIDTH-1:0] next_trial;

    sync_2ff #(.WIDTH(1)) u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_s)
    );

    // Bit-level update of the trial word: only set/clear, no arithmetic.
    always_comb begin
        cur_mask        = '0;
        cur_mask[idx_q] = 1'b1;
        kept            = cmp_s ? trial_q : (trial_q & ~cur_mask);
        next_trial      = kept | (cur_mask >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            trial_q  <= '0;
            dac_q    <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q inside {ST_SAMPLE, ST_SETTLE, ST_DECIDE})) begin
                state_q  <= ST_IDLE;
                dac_q    <= '0;
                sample_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        // abort here is a no-op but still masks start
                        if (start && !abort) begin
                            state_q  <= ST_SAMPLE;
                            trial_q  <= '0;
                            dac_q    <= '0;
                            sample_q <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_q    <= CNT_W'(SAMPLE_CYCLES - 1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_SAMPLE: begin
                        if (cnt_q == '0) begin
                            state_q  <= ST_SETTLE;
                            sample_q <= 1'b0;
                            idx_q    <= IDX_W'(WIDTH - 1);
                            trial_q  <= TOP_BIT;
                            dac_q    <= TOP_BIT;
                            cnt_q    <= CNT_W'(SETTLE_CYCLES - 1);
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DECIDE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        if (idx_q != '0) begin
                            state_q <= ST_SETTLE;
                            idx_q   <= idx_q - 1'b1;
                            trial_q <= next_trial;
                            dac_q   <= next_trial;
                            cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                        end else begin
                            state_q  <= ST_DONE;
                            trial_q  <= kept;
                            result_q <= kept;
                            done_q   <= 1'b1;
                            dac_q    <= '0;
                            busy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        dac_q    <= '0;
                        sample_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dac_code  = dac_q;
    assign sample_en = sample_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl
//   Scoreboard bench for sar_adc_ctrl with an ideal comparator
//   (cmp_in = VIN >= dac_code). Stimulus pushes expected results and
//   done times; a monitor pops and compares on every done pulse.
module tb_sar_adc_ctrl;

    localparam int W   = 8;
    localparam int SC  = 2;
    localparam int TC  = 4;
    // done is visible in the LAT-th cycle after the accepting edge
    localparam int LAT = SC + W * (TC + 1) + 1;

    typedef struct {
        int res;
        int at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp_in;
    logic [W-1:0] dac_code;
    logic         sample_en;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int   vin = 0;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    bit   cont_mode = 0;
    int   busy_err = 0;
    bit   trace_on = 0;
    int   trace_last = 0;
    int   trace_run = 0;
    int   s_cnt = 0;
    exp_t exp_q[$];
    int   codes_q[$];
    int   runs_q[$];

    assign cmp_in = (vin >= int'(dac_code));

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cmp_in    (cmp_in),
        .dac_code  (dac_code),
        .sample_en (sample_en),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Ideal binary search: sequence of trial codes for a given input.
    function automatic void model_trials(input int v, output int tr[W]);
        int code;
        code = 0;
        for (int b = W - 1; b >= 0; b--) begin
            tr[W-1-b] = code + (2 ** b);
            if (v >= tr[W-1-b]) code = tr[W-1-b];
        end
    endfunction

    // Ideal ADC transfer: clamp to the code range.
    function automatic int model_result(input int v);
        if (v < 0) return 0;
        if (v > (2 ** W) - 1) return (2 ** W) - 1;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            chk("done_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", int'(result), e.res);
                chk("done_cycle", edge_n, e.at);
            end
        end
        if (cont_mode && (busy == done)) busy_err++;
    end

    always @(negedge clk) begin
        if (trace_on) begin
            if (sample_en) s_cnt++;
            if (int'(dac_code) == trace_last) begin
                trace_run++;
            end else begin
                if (trace_last != 0) runs_q.push_back(trace_run);
                if (dac_code != 0) codes_q.push_back(int'(dac_code));
                trace_run  = 1;
                trace_last = int'(dac_code);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_conv(input int v, input int junk_at);
        int a;
        tick();
        vin   = v;
        start = 1'b1;
        a     = edge_n;
        exp_q.push_back('{res: model_result(v), at: a + LAT});
        tick();
        start = 1'b0;
        for (int k = 1; k < LAT + 8 && exp_q.size() != 0; k++) begin
            start = (junk_at != 0 && k == junk_at);
            tick();
        end
        start = 1'b0;
        chk("conv_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tr[W];
        int a;
        int d0;
        logic [7:0] vals[256];
        logic [7:0] tmp;
        int j;

        #1;
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sample", int'(sample_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Traced conversion of 0xA5: trial codes, hold times, sample width
        trace_on = 1; trace_last = 0; trace_run = 0; s_cnt = 0;
        codes_q.delete(); runs_q.delete();
        do_conv(8'hA5, 0);
        trace_on = 0;
        model_trials(8'hA5, tr);
        chk("trial_count", codes_q.size(), W);
        for (int i = 0; i < W; i++)
            if (i < codes_q.size()) chk($sformatf("trial_%0d", i), codes_q[i], tr[i]);
        chk("hold_count", runs_q.size(), W);
        for (int i = 0; i < runs_q.size(); i++)
            chk($sformatf("hold_%0d", i), runs_q[i], TC + 1);
        chk("sample_cycles", s_cnt, SC);
        tick();
        chk("idle_after_done", int'(busy), 0);
        chk("result_held", int'(result), 8'hA5);

        do_conv(8'h00, 0);
        do_conv(8'hFF, 0);
        do_conv(300, 0);          // above full scale clamps to all ones
        do_conv(8'h55, 10);       // start during conversion is ignored

        // start held high: back-to-back conversions LAT apart
        d0 = done_cnt;
        tick();
        vin = 8'h3C; start = 1'b1; a = edge_n; cont_mode = 1;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{res: 8'h3C, at: a + k * LAT});
        for (int k = 0; k < 5 * LAT && edge_n < a + 4 * LAT - 5; k++) tick();
        start = 1'b0;
        for (int k = 0; k < 2 * LAT && exp_q.size() != 0; k++) tick();
        cont_mode = 0;
        chk("cont_timeout", exp_q.size(), 0);
        exp_q.delete();
        chk("cont_done_count", done_cnt - d0, 4);
        chk("cont_busy_err", busy_err, 0);

        // abort mid-conversion keeps the old result
        do_conv(8'h12, 0);
        d0 = done_cnt;
        tick();
        vin = 8'h77; start = 1'b1; a = edge_n;
        tick();
        start = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_sample", int'(sample_en), 0);
        chk("abort_result", int'(result), 8'h12);
        // abort with start in IDLE: start ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_idle_busy", int'(busy), 0);
        repeat (LAT + 5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_result_kept", int'(result), 8'h12);
        do_conv(8'h9E, 0);

        // asynchronous reset mid-SETTLE
        tick();
        vin = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac", int'(dac_code), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sample", int'(sample_en), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_result", int'(result), 0);
        tick();
        rst_n = 1'b1;
        do_conv(8'h81, 0);

        // full sweep in random order, random gaps, random ignored starts
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(2, 0)) tick();
            do_conv(int'(vals[i]), ($urandom_range(3, 0) == 0) ? int'($urandom_range(41, 1)) : 0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
